// File: rtl/btb_update_arbiter_if.sv
// Bundle of branch-resolution lanes, BTB write-port signals and status outputs
// for btb_update_arbiter; master drives the lanes, slave is the arbiter.
`ifndef XLEN
`define XLEN 32
`endif

interface btb_update_arbiter_if #(
  parameter int NUM_REQ     = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int DROP_CNT_W  = 8
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_taken;
  logic [NUM_REQ*`XLEN-1:0]   req_PC;
  logic [NUM_REQ*`XLEN-1:0]   req_target_PC;
  logic                       squash;
  logic                       btb_wr_ready;
  logic                       req_ready;
  logic                       result_enable;
  logic                       result_taken;
  logic [`XLEN-1:0]           result_PC;
  logic [`XLEN-1:0]           result_target_PC;
  logic [CNT_W-1:0]           queue_count;
  logic [DROP_CNT_W-1:0]      drop_count;

  modport master (
    output req_valid, req_taken, req_PC, req_target_PC, squash, btb_wr_ready,
    input  req_ready, result_enable, result_taken, result_PC, result_target_PC,
           queue_count, drop_count
  );

  modport slave (
    input  req_valid, req_taken, req_PC, req_target_PC, squash, btb_wr_ready,
    output req_ready, result_enable, result_taken, result_PC, result_target_PC,
           queue_count, drop_count
  );
endinterface

// File: rtl/btb_update_arbiter.sv
// Serializes taken-branch updates from several resolution lanes into the
// single BTB write port through an in-order FIFO with overflow drop counting.
`ifndef XLEN
`define XLEN 32
`endif

module btb_update_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int DROP_CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  btb_update_arbiter_if.slave  bus
);
  localparam int XL      = `XLEN;
  localparam int PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);
  localparam int SPACE_W = CNT_W + 1;
  localparam int DNUM_W  = $clog2(NUM_REQ + 1);

  logic [XL-1:0]          pc_mem  [QUEUE_DEPTH];
  logic [XL-1:0]          tgt_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [CNT_W-1:0]       count;
  logic [DROP_CNT_W-1:0]  drops;

  logic [NUM_REQ-1:0]     cand;
  logic [NUM_REQ-1:0]     keep;
  logic [NUM_REQ-1:0]     wr_en;
  logic [PTR_W-1:0]       wr_idx [NUM_REQ];
  logic [SPACE_W-1:0]     space;
  logic [SPACE_W-1:0]     enq_num;
  logic [DNUM_W-1:0]      drop_num;
  logic [CNT_W-1:0]       count_nx;
  logic [DROP_CNT_W:0]    drop_sum;
  logic [DROP_CNT_W-1:0]  drops_nx;
  logic                   nonempty;
  logic                   pop;

  assign nonempty = (count != '0);
  assign pop      = nonempty && bus.btb_wr_ready && !bus.squash;
  assign space    = SPACE_W'(QUEUE_DEPTH) - SPACE_W'(count) + SPACE_W'(pop);

  // A younger lane with the same PC supersedes an older one in the same cycle.
  always_comb begin
    cand = bus.req_valid & bus.req_taken;
    keep = cand;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (cand[j] && (bus.req_PC[j*XL +: XL] == bus.req_PC[i*XL +: XL])) begin
          keep[i] = 1'b0;
        end
      end
    end
  end

  // NOTE: every variable gets a default before the loop so no latch is inferred,
  // and blocking assignments let enq_num accumulate lane by lane in one pass.
  always_comb begin
    enq_num  = '0;
    drop_num = '0;
    wr_en    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_idx[i] = tail;
      if (keep[i] && !bus.squash) begin
        if (enq_num < space) begin
          wr_en[i]  = 1'b1;
          wr_idx[i] = tail + enq_num[PTR_W-1:0];
          enq_num   = enq_num + SPACE_W'(1);
        end else begin
          drop_num  = drop_num + DNUM_W'(1);
        end
      end
    end
  end

  always_comb begin
    count_nx = CNT_W'(SPACE_W'(count) + enq_num - SPACE_W'(pop));
    drop_sum = {1'b0, drops} + (DROP_CNT_W + 1)'(drop_num);
    drops_nx = drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      drops <= '0;
    end else if (bus.squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PTR_W'(1);
      tail  <= tail + enq_num[PTR_W-1:0];
      count <= count_nx;
      drops <= drops_nx;
    end
  end

  // NOTE: entry storage has no reset; count gates every read, so stale data is never visible.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_en[i]) begin
        pc_mem[wr_idx[i]]  <= bus.req_PC[i*XL +: XL];
        tgt_mem[wr_idx[i]] <= bus.req_target_PC[i*XL +: XL];
      end
    end
  end

  assign bus.result_enable    = pop;
  assign bus.result_taken     = pop;
  assign bus.result_PC        = nonempty ? pc_mem[head]  : '0;
  assign bus.result_target_PC = nonempty ? tgt_mem[head] : '0;
  assign bus.queue_count      = count;
  assign bus.drop_count       = drops;
  assign bus.req_ready        = (SPACE_W'(QUEUE_DEPTH) - SPACE_W'(count)) >= SPACE_W'(NUM_REQ);

endmodule

// File: tb/tb_btb_update_arbiter.sv
// Randomized and directed bench for btb_update_arbiter against a queue-based
// reference model of the update FIFO.
`ifndef XLEN
`define XLEN 32
`endif

module tb_btb_update_arbiter;
  localparam int NUM_REQ     = 2;
  localparam int QUEUE_DEPTH = 4;
  localparam int DROP_CNT_W  = 8;
  localparam int XL          = `XLEN;
  localparam int DROP_MAX    = (1 << DROP_CNT_W) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  btb_update_arbiter_if #(.NUM_REQ(NUM_REQ), .QUEUE_DEPTH(QUEUE_DEPTH), .DROP_CNT_W(DROP_CNT_W)) bus ();

  btb_update_arbiter #(.NUM_REQ(NUM_REQ), .QUEUE_DEPTH(QUEUE_DEPTH), .DROP_CNT_W(DROP_CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [XL-1:0] pc;
    logic [XL-1:0] tgt;
  } ent_t;

  ent_t mq[$];
  int   mdrop;
  int   checks;
  int   failures;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, compare DUT against the model, then advance the model.
  task automatic cycle(input logic [1:0] v, input logic [1:0] t,
                       input logic [XL-1:0] pc0, input logic [XL-1:0] tg0,
                       input logic [XL-1:0] pc1, input logic [XL-1:0] tg1,
                       input logic sq, input logic rdy);
    logic [XL-1:0] pcs [NUM_REQ];
    logic [XL-1:0] tgs [NUM_REQ];
    bit            cand [NUM_REQ];
    bit            keep [NUM_REQ];
    bit            exp_pop;
    int            n;
    ent_t          e;
    pcs[0] = pc0; pcs[1] = pc1;
    tgs[0] = tg0; tgs[1] = tg1;
    bus.req_valid     = v;
    bus.req_taken     = t;
    bus.req_PC        = {pc1, pc0};
    bus.req_target_PC = {tg1, tg0};
    bus.squash        = sq;
    bus.btb_wr_ready  = rdy;
    @(negedge clock);
    n       = mq.size();
    exp_pop = (n != 0) && rdy && !sq;
    check("result_enable", 64'(bus.result_enable), 64'(exp_pop));
    check("result_taken", 64'(bus.result_taken), 64'(exp_pop));
    if (n != 0) begin
      check("result_PC", 64'(bus.result_PC), 64'(mq[0].pc));
      check("result_target_PC", 64'(bus.result_target_PC), 64'(mq[0].tgt));
    end else begin
      check("result_PC_empty", 64'(bus.result_PC), 64'd0);
      check("result_target_PC_empty", 64'(bus.result_target_PC), 64'd0);
    end
    check("queue_count", 64'(bus.queue_count), 64'(n));
    check("drop_count", 64'(bus.drop_count), 64'(mdrop));
    check("req_ready", 64'(bus.req_ready), 64'((QUEUE_DEPTH - n) >= NUM_REQ));
    if (sq) begin
      mq.delete();
    end else begin
      if (exp_pop) void'(mq.pop_front());
      for (int i = 0; i < NUM_REQ; i++) cand[i] = v[i] && t[i];
      for (int i = 0; i < NUM_REQ; i++) begin
        keep[i] = cand[i];
        for (int j = i + 1; j < NUM_REQ; j++)
          if (cand[j] && pcs[j] == pcs[i]) keep[i] = 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (keep[i]) begin
          if (mq.size() < QUEUE_DEPTH) begin
            e.pc = pcs[i]; e.tgt = tgs[i];
            mq.push_back(e);
          end else if (mdrop < DROP_MAX) begin
            mdrop++;
          end
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(2'b00, 2'b00, '0, '0, '0, '0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    bus.req_valid     = 2'b11;
    bus.req_taken     = 2'b11;
    bus.req_PC        = {32'h0000_0AA0, 32'h0000_0BB0};
    bus.req_target_PC = {32'h0000_0CC0, 32'h0000_0DD0};
    bus.squash        = 1'b1;
    bus.btb_wr_ready  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    mq.delete();
    mdrop = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mdrop    = 0;
    do_reset();
    idle(1'b1);

    // Single lane-0 update appears one cycle later and drains.
    cycle(2'b01, 2'b01, 32'h100, 32'h200, '0, '0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Two lanes in one cycle, stalled write port, then in-order drain.
    cycle(2'b11, 2'b11, 32'h40, 32'h44, 32'h80, 32'h88, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    repeat (3) idle(1'b1);

    // Same-PC coalescing keeps the younger lane only.
    cycle(2'b11, 2'b11, 32'h300, 32'h400, 32'h300, 32'h500, 1'b0, 1'b0);
    check("coalesce_count", 64'(bus.queue_count), 64'd1);
    check("coalesce_target", 64'(bus.result_target_PC), 64'h500);
    idle(1'b1);

    // Lane 1 valid but not taken never enqueues.
    cycle(2'b10, 2'b00, '0, '0, 32'h600, 32'h700, 1'b0, 1'b0);
    idle(1'b1);

    // Full queue with simultaneous pop and enqueue.
    cycle(2'b11, 2'b11, 32'h10, 32'h11, 32'h20, 32'h21, 1'b0, 1'b0);
    cycle(2'b11, 2'b11, 32'h30, 32'h31, 32'h50, 32'h51, 1'b0, 1'b0);
    cycle(2'b01, 2'b01, 32'h500, 32'h501, '0, '0, 1'b0, 1'b1);
    check("full_pop_enq_count", 64'(bus.queue_count), 64'(QUEUE_DEPTH));
    repeat (5) idle(1'b1);

    // Squash with a pending update and an incoming candidate.
    cycle(2'b11, 2'b11, 32'h1000, 32'h1001, 32'h2000, 32'h2001, 1'b0, 1'b0);
    cycle(2'b01, 2'b01, 32'h3000, 32'h3001, '0, '0, 1'b0, 1'b0);
    cycle(2'b01, 2'b01, 32'h4000, 32'h4001, '0, '0, 1'b1, 1'b1);
    check("squash_count", 64'(bus.queue_count), 64'd0);
    idle(1'b1);

    // Random traffic with a small PC pool so coalescing and overflow both occur.
    for (int k = 0; k < 400; k++) begin
      cycle(2'($urandom), 2'($urandom),
            XL'({$urandom_range(0, 3), 4'h0}), XL'($urandom),
            XL'({$urandom_range(0, 3), 4'h0}), XL'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
    end

    // Overflow drops and saturation of the drop counter.
    do_reset();
    idle(1'b0);
    cycle(2'b11, 2'b11, 32'h10, 32'h11, 32'h20, 32'h21, 1'b0, 1'b0);
    cycle(2'b11, 2'b11, 32'h30, 32'h31, 32'h40, 32'h41, 1'b0, 1'b0);
    cycle(2'b11, 2'b11, 32'h50, 32'h51, 32'h60, 32'h61, 1'b0, 1'b0);
    check("first_drops", 64'(bus.drop_count), 64'd2);
    check("full_not_ready", 64'(bus.req_ready), 64'd0);
    for (int k = 0; k < 130; k++)
      cycle(2'b11, 2'b11, 32'h70, 32'h71, 32'h80, 32'h81, 1'b0, 1'b0);
    check("drop_saturated", 64'(bus.drop_count), 64'(DROP_MAX));
    cycle(2'b01, 2'b01, 32'h90, 32'h91, '0, '0, 1'b1, 1'b1);
    check("squash_keeps_drops", 64'(bus.drop_count), 64'(DROP_MAX));
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
